mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_mem_pkg.sv | 29 ++
 rtl/starve_counter.sv | 39 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W             = 32;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned STRB_W             = DATA_W / 8;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  // Which port owns the SRAM response returning next cycle.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_INST = 2'd1,
    OWNER_DATA = 2'd2
  } resp_owner_e;

  // One SRAM access as driven onto the shared port.
  typedef struct packed {
    logic              en;
    logic [STRB_W-1:0] wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  // Counter width able to hold 0..max (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter with synchronous clear; counts data grants a fetch has waited through.
module starve_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear dominates, increment holds at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_max_c = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-cycle-latency SRAM, data first with starvation guard.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [STRB_W-1:0] d_wstrb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  // shared SRAM
  output logic              sram_en,
  output logic [STRB_W-1:0] sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned CNT_W = cnt_width(STARVE_MAX);

  logic              grant_i_c;
  logic              grant_d_c;
  logic              starve_inc_c;
  logic              starve_clr_c;
  logic              starve_at_max_c;
  logic [CNT_W-1:0]  starve_cnt;
  sram_req_t         sram_c;

  resp_owner_e       resp_owner_q;
  resp_owner_e       resp_owner_d;
  logic              cancel_q;
  logic              cancel_d;

  // Grant decision: data wins unless the fetch has waited STARVE_MAX data grants.
  always_comb begin
    grant_i_c = 1'b0;
    grant_d_c = 1'b0;
    if (!rst) begin
      if (i_req && (!d_req || starve_at_max_c)) begin
        grant_i_c = 1'b1;
      end else if (d_req) begin
        grant_d_c = 1'b1;
      end
    end
  end

  // Starvation bookkeeping only advances while a fetch is actually waiting.
  always_comb begin
    starve_inc_c = grant_d_c && i_req;
    starve_clr_c = grant_i_c || !i_req;
  end

  starve_counter #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc_c),
    .clr      (starve_clr_c),
    .cnt      (starve_cnt),
    .at_max_c (starve_at_max_c)
  );

  // SRAM request mux; idle cycles drive all zeros.
  always_comb begin
    sram_c = '0;
    if (grant_i_c) begin
      sram_c.en   = 1'b1;
      sram_c.addr = i_addr;
    end else if (grant_d_c) begin
      sram_c.en    = 1'b1;
      sram_c.addr  = d_addr;
      sram_c.wdata = d_wdata;
      sram_c.wen   = d_wr ? d_wstrb : '0;
    end
  end

  // Response owner and cancel mark for the access issued this cycle.
  always_comb begin
    resp_owner_d = OWNER_NONE;
    cancel_d     = 1'b0;
    if (grant_i_c) begin
      resp_owner_d = OWNER_INST;
      cancel_d     = i_cancel;
    end else if (grant_d_c) begin
      resp_owner_d = OWNER_DATA;
    end
  end

  // Response tracking registers; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_owner_q <= OWNER_NONE;
      cancel_q     <= 1'b0;
    end else begin
      resp_owner_q <= resp_owner_d;
      cancel_q     <= cancel_d;
    end
  end

  assign i_addr_ok  = grant_i_c;
  assign d_addr_ok  = grant_d_c;

  assign sram_en    = sram_c.en;
  assign sram_wen   = sram_c.wen;
  assign sram_addr  = sram_c.addr;
  assign sram_wdata = sram_c.wdata;

  assign i_data_ok  = (resp_owner_q == OWNER_INST) && !cancel_q;
  assign d_data_ok  = (resp_owner_q == OWNER_DATA);
  assign i_rdata    = i_data_ok ? sram_rdata : '0;
  assign d_rdata    = d_data_ok ? sram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned STARVE = 4;
  localparam int PORT_I = 1;
  localparam int PORT_D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_cancel, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata, sram_rdata;
  logic [3:0]  d_wstrb;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, sram_en;
  logic [31:0] i_rdata, d_rdata, sram_addr, sram_wdata;
  logic [3:0]  sram_wen;

  typedef struct {
    int          port;
    logic [31:0] data;
    bit          canc;
  } resp_t;

  resp_t exp_q[$];
  int    starve;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    n_grant_live = 0;
  int    n_ok_seen    = 0;
  bit    last_gi;

  mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_cancel   (i_cancel),
    .i_addr_ok  (i_addr_ok),
    .i_data_ok  (i_data_ok),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_wstrb    (d_wstrb),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_addr_ok  (d_addr_ok),
    .d_data_ok  (d_data_ok),
    .d_rdata    (d_rdata),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_cancel = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_wr = 1'b0; d_wstrb = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  // One clock: called at posedge+1 with inputs applied; samples mid-cycle, advances model, returns at next posedge+1.
  task automatic run_cycle();
    resp_t       r;
    bit          have, gi, gd, exp_iok, exp_dok;
    logic [31:0] e_addr, e_wdata, next_rdata;
    logic [3:0]  e_wen;
    #5;
    cyc++;
    have = 1'b0;
    if (exp_q.size() > 0) begin
      r    = exp_q.pop_front();
      have = 1'b1;
    end
    gi = 1'b0; gd = 1'b0;
    if (rst) begin
      exp_q.delete();
      have   = 1'b0;
      starve = 0;
    end else begin
      // Data is preferred; a waiting fetch is forced through after STARVE data grants.
      gi = i_req && (!d_req || starve == int'(STARVE));
      gd = d_req && !gi;
    end
    e_addr  = gi ? i_addr : (gd ? d_addr : 32'h0);
    e_wdata = gd ? d_wdata : 32'h0;
    e_wen   = (gd && d_wr) ? d_wstrb : 4'h0;
    last_gi = gi;

    check("i_addr_ok", 32'(i_addr_ok), 32'(gi));
    check("d_addr_ok", 32'(d_addr_ok), 32'(gd));
    check("sram_en", 32'(sram_en), 32'(gi | gd));
    check("sram_wen", 32'(sram_wen), 32'(e_wen));
    check("sram_addr", sram_addr, e_addr);
    check("sram_wdata", sram_wdata, e_wdata);

    exp_iok = have && r.port == PORT_I && !r.canc;
    exp_dok = have && r.port == PORT_D;
    check("i_data_ok", 32'(i_data_ok), 32'(exp_iok));
    check("d_data_ok", 32'(d_data_ok), 32'(exp_dok));
    if (!(have && r.port == PORT_I && r.canc))
      check("i_rdata", i_rdata, exp_iok ? r.data : 32'h0);
    check("d_rdata", d_rdata, exp_dok ? r.data : 32'h0);
    if (i_data_ok || d_data_ok) n_ok_seen++;

    if (!rst) begin
      if (gi || !i_req) starve = 0;
      else if (gd && starve < int'(STARVE)) starve++;
      if (gi) exp_q.push_back('{port: PORT_I, data: i_addr + 32'd1, canc: i_cancel});
      if (gd) exp_q.push_back('{port: PORT_D, data: d_addr + 32'd1, canc: 1'b0});
      if (gd || (gi && !i_cancel)) n_grant_live++;
    end

    // SRAM model: returns address+1 for the access presented this cycle, noise otherwise.
    next_rdata = sram_en ? sram_addr + 32'd1 : $urandom;
    @(posedge clk);
    #1;
    sram_rdata = next_rdata;
  endtask

  initial begin
    int g0, o0;
    rst = 1'b1;
    sram_rdata = 32'h0;
    starve = 0;
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset holds everything quiet even with both ports requesting.
    i_req = 1'b1; d_req = 1'b1; d_wr = 1'b1; d_wstrb = 4'hF;
    i_addr = 32'h1000; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D;
    repeat (2) run_cycle();
    rst = 1'b0;
    idle_inputs();
    run_cycle();

    // Fetch-only streaming from the boot vector.
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    repeat (8) run_cycle();
    i_req = 1'b0;
    run_cycle();

    // Both ports saturated: four data grants, then one fetch, repeating.
    for (int k = 0; k < 20; k++) begin
      i_req = 1'b1; i_addr = 32'hBFC0_0100 + 32'(k * 4);
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h8000_0000 + 32'(k * 4);
      run_cycle();
      check("starve_pattern", 32'(last_gi), 32'((k % 5) == 4));
    end
    idle_inputs();
    run_cycle();

    // Partial-word data write racing a fetch.
    i_req = 1'b1; i_addr = 32'hBFC0_0200;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h8000_1000; d_wstrb = 4'b0011; d_wdata = 32'h1234_5678;
    run_cycle();
    idle_inputs();
    run_cycle();
    run_cycle();

    // Cancelled fetch followed by a fresh fetch that must return.
    i_req = 1'b1; i_addr = 32'hBFC0_0300; i_cancel = 1'b1;
    run_cycle();
    i_addr = 32'hBFC0_0304; i_cancel = 1'b0;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Reset with a read in flight, then starvation sequence restarts from zero.
    d_req = 1'b1; d_addr = 32'h8000_2000;
    run_cycle();
    rst = 1'b1; i_req = 1'b1; i_addr = 32'hBFC0_0400;
    run_cycle();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      run_cycle();
      check("post_rst_pattern", 32'(last_gi), 32'(k == 4));
    end
    idle_inputs();
    run_cycle();

    // Alternating single requests with gaps: one response per grant, nothing extra.
    g0 = n_grant_live; o0 = n_ok_seen;
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      if (k % 2 == 0) begin
        i_req = 1'b1; i_addr = 32'hBFC0_1000 + 32'(k * 4);
      end else begin
        d_req = 1'b1; d_wr = k[1]; d_wstrb = 4'hC; d_addr = 32'h8000_3000 + 32'(k * 4); d_wdata = $urandom;
      end
      run_cycle();
      idle_inputs();
      repeat (1 + (k % 3)) run_cycle();
    end
    check("resp_count", 32'(n_ok_seen - o0), 32'(n_grant_live - g0));

    // Randomized traffic including cancels and occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 49) == 0);
      i_req    = ($urandom_range(0, 3) != 0);
      i_addr   = $urandom;
      i_cancel = ($urandom_range(0, 5) == 0);
      d_req    = ($urandom_range(0, 2) != 0);
      d_wr     = $urandom_range(0, 1) == 1;
      d_wstrb  = 4'($urandom);
      d_addr   = $urandom;
      d_wdata  = $urandom;
      run_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (2) run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
